scarv_cop_mem_arb: RTL and testbench

Two-requester arbiter that shares the single COP memory port (cen/wen/addr/wdata/ben/rdata/stall/error) between requester 0, the COP load/store unit, and requester 1, the scatter/gather engine.
- Grants one new transaction per cycle whenever the memory can accept one.
- Tracks which requester owns the outstanding transaction and routes its response back to it.
- Holds the issued request stable on the memory side while the memory stalls.
- Sits between the COP execute stage and the top-level cop_mem_* pins.

---
 rtl/scarv_cop_pkg.sv | 18 +
 rtl/scarv_cop_mem_arb_pick.sv | 26 ++
 rtl/scarv_cop_mem_arb.sv | 170 +++++++++++++++++
 tb/tb_scarv_cop_mem_arb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scarv_cop_pkg.sv
// Shared constants for the COP memory arbiter: state encoding, requester ids, default widths.
package scarv_cop_pkg;

    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_OWN0 = 2'd1;
    localparam logic [1:0] ARB_OWN1 = 2'd2;

    localparam int REQ_LSU = 0;
    localparam int REQ_SG  = 1;

    function automatic logic [1:0] arb_own_state(input logic [1:0] gnt);
        return gnt[REQ_SG] ? ARB_OWN1 : ARB_OWN0;
    endfunction

endpackage

// File: rtl/scarv_cop_mem_arb_pick.sv
// Combinational 2-way picker producing a one-hot grant; zero latency, no backpressure of its own.
// SCARV_COP_MEM_ARB_RR_EN selects round-robin on ptr, otherwise requester 0 has fixed priority.
module scarv_cop_mem_arb_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

`ifdef SCARV_COP_MEM_ARB_RR_EN
    // ptr names the requester preferred when both ask in the same cycle.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ptr;

    always_comb begin
        gnt = {req[1] & ~req[0], req[0]};
    end
`endif

endmodule

// File: rtl/scarv_cop_mem_arb.sv
// Shares the COP memory port between the LSU (r0) and scatter/gather (r1); grant is combinational,
// response one or more cycles later; mem_stall blocks new grants and freezes the issued request.
// Optional SCARV_COP_MEM_ARB_RR_EN enables round-robin arbitration instead of r0 fixed priority.
module scarv_cop_mem_arb
    import scarv_cop_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            r0_cen,
    input  logic            r0_wen,
    input  logic [AW-1:0]   r0_addr,
    input  logic [DW-1:0]   r0_wdata,
    input  logic [DW/8-1:0] r0_ben,
    output logic            r0_gnt,
    output logic            r0_stall,
    output logic [DW-1:0]   r0_rdata,
    output logic            r0_error,
    input  logic            r1_cen,
    input  logic            r1_wen,
    input  logic [AW-1:0]   r1_addr,
    input  logic [DW-1:0]   r1_wdata,
    input  logic [DW/8-1:0] r1_ben,
    output logic            r1_gnt,
    output logic            r1_stall,
    output logic [DW-1:0]   r1_rdata,
    output logic            r1_error,
    output logic            mem_cen,
    output logic            mem_wen,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_ben,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_stall,
    input  logic            mem_error
);

    localparam int BW = DW / 8;

    logic [1:0]    state_q, state_d;
    logic          hold_wen_q, hold_wen_d;
    logic [AW-1:0] hold_addr_q, hold_addr_d;
    logic [DW-1:0] hold_wdata_q, hold_wdata_d;
    logic [BW-1:0] hold_ben_q, hold_ben_d;
    logic          can_issue;
    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          pick_ptr;

    // Gating with g_resetn keeps every output low while reset is held, grant path included.
    assign can_issue = (state_q == ARB_IDLE) || !mem_stall;
    assign req       = {r1_cen, r0_cen} & {2{can_issue & g_resetn}};

`ifdef SCARV_COP_MEM_ARB_RR_EN
    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (|gnt) begin
            ptr_d = gnt[REQ_LSU];
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign pick_ptr = ptr_q;
`else
    assign pick_ptr = 1'b0;
`endif

    scarv_cop_mem_arb_pick u_pick (
        .req (req),
        .ptr (pick_ptr),
        .gnt (gnt)
    );

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (|gnt) begin
            state_d = arb_own_state(gnt);
        end else if (state_q != ARB_IDLE && !mem_stall) begin
            state_d = ARB_IDLE;
        end
    end

    always_comb begin
        hold_wen_d   = hold_wen_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        hold_ben_d   = hold_ben_q;
        if (gnt[REQ_LSU]) begin
            hold_wen_d   = r0_wen;
            hold_addr_d  = r0_addr;
            hold_wdata_d = r0_wdata;
            hold_ben_d   = r0_ben;
        end else if (gnt[REQ_SG]) begin
            hold_wen_d   = r1_wen;
            hold_addr_d  = r1_addr;
            hold_wdata_d = r1_wdata;
            hold_ben_d   = r1_ben;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            hold_wen_q   <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            hold_ben_q   <= '0;
        end else begin
            hold_wen_q   <= hold_wen_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            hold_ben_q   <= hold_ben_d;
        end
    end

    always_comb begin
        r0_gnt    = gnt[REQ_LSU];
        r1_gnt    = gnt[REQ_SG];
        mem_cen   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_ben   = '0;
        if (gnt[REQ_LSU]) begin
            mem_cen   = 1'b1;
            mem_wen   = r0_wen;
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
            mem_ben   = r0_ben;
        end else if (gnt[REQ_SG]) begin
            mem_cen   = 1'b1;
            mem_wen   = r1_wen;
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
            mem_ben   = r1_ben;
        end else if (state_q != ARB_IDLE && mem_stall) begin
            mem_cen   = 1'b1;
            mem_wen   = hold_wen_q;
            mem_addr  = hold_addr_q;
            mem_wdata = hold_wdata_q;
            mem_ben   = hold_ben_q;
        end

        r0_stall = (state_q == ARB_OWN0) && mem_stall;
        r0_error = (state_q == ARB_OWN0) && mem_error;
        r0_rdata = (state_q == ARB_OWN0) ? mem_rdata : '0;
        r1_stall = (state_q == ARB_OWN1) && mem_stall;
        r1_error = (state_q == ARB_OWN1) && mem_error;
        r1_rdata = (state_q == ARB_OWN1) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_scarv_cop_mem_arb.sv
// Bench for scarv_cop_mem_arb: directed cycle table, hand-written corner sequences, random traffic vs model.
module tb_scarv_cop_mem_arb;

    localparam logic [31:0] WD0 = 32'h1111_1111;
    localparam logic [3:0]  B0  = 4'hF;
    localparam logic [31:0] WD1 = 32'h55AA_55AA;
    localparam logic [3:0]  B1  = 4'b0011;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        r0_cen, r0_wen, r0_gnt, r0_stall, r0_error;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic [3:0]  r0_ben;
    logic        r1_cen, r1_wen, r1_gnt, r1_stall, r1_error;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic [3:0]  r1_ben;
    logic        mem_cen, mem_wen, mem_stall, mem_error;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_ben;

    always #5 g_clk = ~g_clk;

    scarv_cop_mem_arb #(.AW(32), .DW(32)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .r0_cen(r0_cen), .r0_wen(r0_wen), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_ben(r0_ben),
        .r0_gnt(r0_gnt), .r0_stall(r0_stall), .r0_rdata(r0_rdata), .r0_error(r0_error),
        .r1_cen(r1_cen), .r1_wen(r1_wen), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_ben(r1_ben),
        .r1_gnt(r1_gnt), .r1_stall(r1_stall), .r1_rdata(r1_rdata), .r1_error(r1_error),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ben(mem_ben), .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_error(mem_error)
    );

    typedef struct packed {
        logic rstn;
        logic c0, w0; logic [31:0] a0, d0; logic [3:0] b0;
        logic c1, w1; logic [31:0] a1, d1; logic [3:0] b1;
        logic stall, err; logic [31:0] rdata;
    } i_t;

    typedef struct packed {
        logic g0, g1, s0, s1, e0, e1;
        logic [31:0] rd0, rd1;
        logic mcen, mwen;
        logic [31:0] maddr, mwd;
        logic [3:0] mben;
    } o_t;

    typedef struct { i_t in; o_t exp; } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl[$];

    // A requester must keep cen high until it is granted.
    logic pend0_q = 1'b0, pend1_q = 1'b0;
    always @(posedge g_clk) begin
        if (g_resetn && pend0_q) assert (r0_cen) else $error("FAIL proto_r0: cen dropped before grant");
        if (g_resetn && pend1_q) assert (r1_cen) else $error("FAIL proto_r1: cen dropped before grant");
        pend0_q <= g_resetn && r0_cen && !r0_gnt;
        pend1_q <= g_resetn && r1_cen && !r1_gnt;
    end

    function automatic i_t mk_in(logic rstn, logic c0, logic [31:0] a0, logic c1, logic w1,
                                 logic [31:0] a1, logic stall, logic err, logic [31:0] rdata);
        i_t v = '0;
        v.rstn = rstn; v.c0 = c0; v.a0 = a0; v.d0 = WD0; v.b0 = B0;
        v.c1 = c1; v.w1 = w1; v.a1 = a1; v.d1 = WD1; v.b1 = B1;
        v.stall = stall; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    // src: -1 idle memory side, 0/1 = that requester's fixed wdata/ben on the memory side.
    function automatic o_t mk_out(logic g0, logic g1, int src, logic mwen, logic [31:0] maddr,
                                  logic s0, logic s1, logic [31:0] rd0, logic [31:0] rd1,
                                  logic e0, logic e1);
        o_t o = '0;
        o.g0 = g0; o.g1 = g1; o.s0 = s0; o.s1 = s1; o.e0 = e0; o.e1 = e1;
        o.rd0 = rd0; o.rd1 = rd1;
        o.mcen = (src >= 0); o.mwen = mwen; o.maddr = maddr;
        if (src == 0) begin o.mwd = WD0; o.mben = B0; end
        if (src == 1) begin o.mwd = WD1; o.mben = B1; end
        return o;
    endfunction

    task automatic apply(input i_t v);
        g_resetn = v.rstn;
        r0_cen = v.c0; r0_wen = v.w0; r0_addr = v.a0; r0_wdata = v.d0; r0_ben = v.b0;
        r1_cen = v.c1; r1_wen = v.w1; r1_addr = v.a1; r1_wdata = v.d1; r1_ben = v.b1;
        mem_stall = v.stall; mem_error = v.err; mem_rdata = v.rdata;
    endtask

    function automatic o_t snap();
        o_t o;
        o.g0 = r0_gnt; o.g1 = r1_gnt; o.s0 = r0_stall; o.s1 = r1_stall;
        o.e0 = r0_error; o.e1 = r1_error; o.rd0 = r0_rdata; o.rd1 = r1_rdata;
        o.mcen = mem_cen; o.mwen = mem_wen; o.maddr = mem_addr; o.mwd = mem_wdata; o.mben = mem_ben;
        return o;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic step(input string tag, input i_t v, input o_t e);
        o_t act;
        apply(v);
        #4;
        act = snap();
        n_vec++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, e);
        end
        @(posedge g_clk);
        #1;
    endtask

    bit          pend[2];
    logic        pw[2];
    logic [31:0] pa[2], pd[2];
    logic [3:0]  pb[2];
    logic        hw;
    logic [31:0] ha, hd;
    logic [3:0]  hb;
    int          owner, pref, g;
    logic        prev_mcen;

    initial begin
        o_t Z;
        Z = mk_out(0, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge g_clk);
        #1;

        tbl.push_back(vec_t'{mk_in(0, 1, 'h100, 1, 1, 'h2000, 1, 1, 'hFFFF), Z});
        tbl.push_back(vec_t'{mk_in(1, 1, 'h200, 1, 0, 'h300, 0, 0, 'hA0),
                             mk_out(1, 0, 0, 0, 'h200, 0, 0, 0, 0, 0, 0)});
`ifdef SCARV_COP_MEM_ARB_RR_EN
        tbl.push_back(vec_t'{mk_in(1, 1, 'h200, 1, 0, 'h300, 0, 0, 'hB0),
                             mk_out(0, 1, 1, 0, 'h300, 0, 0, 'hB0, 0, 0, 0)});
        tbl.push_back(vec_t'{mk_in(1, 1, 'h200, 1, 0, 'h300, 0, 0, 'hC0),
                             mk_out(1, 0, 0, 0, 'h200, 0, 0, 0, 'hC0, 0, 0)});
        tbl.push_back(vec_t'{mk_in(1, 1, 'h200, 1, 0, 'h300, 0, 0, 'hD0),
                             mk_out(0, 1, 1, 0, 'h300, 0, 0, 'hD0, 0, 0, 0)});
        tbl.push_back(vec_t'{mk_in(1, 1, 'h200, 0, 0, 0, 0, 0, 'hE0),
                             mk_out(1, 0, 0, 0, 'h200, 0, 0, 0, 'hE0, 0, 0)});
        tbl.push_back(vec_t'{mk_in(1, 0, 0, 0, 0, 0, 0, 0, 'hF0),
                             mk_out(0, 0, -1, 0, 0, 0, 0, 'hF0, 0, 0, 0)});
`else
        tbl.push_back(vec_t'{mk_in(1, 1, 'h200, 1, 0, 'h300, 0, 0, 'hB0),
                             mk_out(1, 0, 0, 0, 'h200, 0, 0, 'hB0, 0, 0, 0)});
        tbl.push_back(vec_t'{mk_in(1, 1, 'h200, 1, 0, 'h300, 0, 0, 'hC0),
                             mk_out(1, 0, 0, 0, 'h200, 0, 0, 'hC0, 0, 0, 0)});
        tbl.push_back(vec_t'{mk_in(1, 1, 'h200, 1, 0, 'h300, 0, 0, 'hD0),
                             mk_out(1, 0, 0, 0, 'h200, 0, 0, 'hD0, 0, 0, 0)});
        tbl.push_back(vec_t'{mk_in(1, 0, 0, 1, 0, 'h300, 0, 0, 'hE0),
                             mk_out(0, 1, 1, 0, 'h300, 0, 0, 'hE0, 0, 0, 0)});
        tbl.push_back(vec_t'{mk_in(1, 0, 0, 0, 0, 0, 0, 0, 'hF0),
                             mk_out(0, 0, -1, 0, 0, 0, 0, 0, 'hF0, 0, 0)});
`endif
        tbl.push_back(vec_t'{mk_in(1, 1, 'h100, 0, 0, 0, 0, 0, 0),
                             mk_out(1, 0, 0, 0, 'h100, 0, 0, 0, 0, 0, 0)});
        tbl.push_back(vec_t'{mk_in(1, 0, 0, 0, 0, 0, 0, 0, 'hDEADBEEF),
                             mk_out(0, 0, -1, 0, 0, 0, 0, 'hDEADBEEF, 0, 0, 0)});

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].in, tbl[i].exp);
        end

        // Stall hold: r1 write frozen on the memory side, r0 locked out.
        step("stall_issue", mk_in(1, 0, 0, 1, 1, 'h2000, 0, 0, 0), mk_out(0, 1, 1, 1, 'h2000, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            step($sformatf("stall_hold%0d", i), mk_in(1, 1, 'h40, 0, 0, 0, 1, 0, 'h77),
                 mk_out(0, 0, 1, 1, 'h2000, 0, 1, 0, 'h77, 0, 0));
        end
        step("stall_done", mk_in(1, 1, 'h40, 0, 0, 0, 0, 0, 'h88), mk_out(1, 0, 0, 0, 'h40, 0, 0, 0, 'h88, 0, 0));

        // Back-to-back issue in the response cycle.
        step("b2b_r0", mk_in(1, 1, 'h10, 0, 0, 0, 0, 0, 'h99), mk_out(1, 0, 0, 0, 'h10, 0, 0, 'h99, 0, 0, 0));
        step("b2b_r1", mk_in(1, 0, 0, 1, 0, 'h14, 0, 0, 'hAB), mk_out(0, 1, 1, 0, 'h14, 0, 0, 'hAB, 0, 0, 0));
        step("b2b_rsp", mk_in(1, 0, 0, 0, 0, 0, 0, 0, 'hCD), mk_out(0, 0, -1, 0, 0, 0, 0, 0, 'hCD, 0, 0));

        // Error response to r1.
        step("err_issue", mk_in(1, 0, 0, 1, 0, 'h20, 0, 0, 0), mk_out(0, 1, 1, 0, 'h20, 0, 0, 0, 0, 0, 0));
        step("err_rsp", mk_in(1, 0, 0, 0, 0, 0, 0, 1, 'hEE), mk_out(0, 0, -1, 0, 0, 0, 0, 0, 'hEE, 0, 1));
        step("err_idle", mk_in(1, 0, 0, 0, 0, 0, 0, 0, 'h12), Z);

        // Reset while r0 owns a stalled transaction.
        step("rst_issue", mk_in(1, 1, 'h30, 0, 0, 0, 0, 0, 0), mk_out(1, 0, 0, 0, 'h30, 0, 0, 0, 0, 0, 0));
        step("rst_stall", mk_in(1, 0, 0, 0, 0, 0, 1, 0, 'h5), mk_out(0, 0, 0, 0, 'h30, 1, 0, 'h5, 0, 0, 0));
        step("rst_low", mk_in(0, 0, 0, 0, 0, 0, 1, 0, 'h6), Z);
        step("rst_after", mk_in(1, 0, 0, 0, 0, 0, 0, 0, 'h7), Z);
        step("rst_new", mk_in(1, 1, 'h34, 0, 0, 0, 0, 0, 'h8), mk_out(1, 0, 0, 0, 'h34, 0, 0, 0, 0, 0, 0));
        step("rst_rsp", mk_in(1, 0, 0, 0, 0, 0, 0, 0, 'h9), mk_out(0, 0, -1, 0, 0, 0, 0, 'h9, 0, 0, 0));

        // Random traffic against a transaction-level model.
        step("rnd_reset", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0), Z);
        owner = -1; pref = 0; prev_mcen = 1'b0;
        pend[0] = 0; pend[1] = 0;
        hw = 0; ha = 0; hd = 0; hb = 0;
        for (int k = 0; k < 2000; k++) begin
            i_t v;
            o_t e;
            logic can;
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && $urandom_range(0, 99) < 50) begin
                    pend[n] = 1;
                    pw[n] = 1'($urandom_range(0, 1));
                    pa[n] = $urandom() & 32'hFFFF_FFFC;
                    pd[n] = $urandom();
                    pb[n] = 4'($urandom_range(0, 15));
                end
            end
            v = '0;
            v.rstn = 1'b1;
            v.c0 = pend[0]; v.w0 = pend[0] ? pw[0] : 1'b0; v.a0 = pa[0]; v.d0 = pd[0]; v.b0 = pb[0];
            v.c1 = pend[1]; v.w1 = pend[1] ? pw[1] : 1'b0; v.a1 = pa[1]; v.d1 = pd[1]; v.b1 = pb[1];
            v.stall = ($urandom_range(0, 99) < 30);
            v.err = prev_mcen && ($urandom_range(0, 3) == 0);
            v.rdata = $urandom();

            can = (owner < 0) || !v.stall;
            g = -1;
            if (can) begin
                if (pend[0] && pend[1]) begin
`ifdef SCARV_COP_MEM_ARB_RR_EN
                    g = pref;
`else
                    g = 0;
`endif
                end else if (pend[0]) begin
                    g = 0;
                end else if (pend[1]) begin
                    g = 1;
                end
            end

            e = '0;
            e.g0 = (g == 0);
            e.g1 = (g == 1);
            if (g >= 0) begin
                e.mcen = 1; e.mwen = pw[g]; e.maddr = pa[g]; e.mwd = pd[g]; e.mben = pb[g];
            end else if (owner >= 0 && v.stall) begin
                e.mcen = 1; e.mwen = hw; e.maddr = ha; e.mwd = hd; e.mben = hb;
            end
            if (owner == 0) begin e.s0 = v.stall; e.rd0 = v.rdata; e.e0 = v.err; end
            if (owner == 1) begin e.s1 = v.stall; e.rd1 = v.rdata; e.e1 = v.err; end

            step($sformatf("rnd%0d", k), v, e);

            if (g >= 0) begin
                hw = pw[g]; ha = pa[g]; hd = pd[g]; hb = pb[g];
                owner = g;
                pend[g] = 0;
                pref = 1 - g;
            end else if (owner >= 0 && !v.stall) begin
                owner = -1;
            end
            prev_mcen = e.mcen;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
